gold_outport_arbiter: RTL and testbench
=======================================

# gold_outport_arbiter

Per-direction output-port arbiter for a gold ring router. It shares one outbound ring link (CW or CCW) between two requesters: ring pass-through traffic and local PE injection. It owns the even/odd virtual-channel output buffers and the global polarity toggle, so the link carries the VC matching polarity in any cycle and the opposite VC's buffer is refilled. Ring traffic is favoured, and a counter keeps the PE from starving.

## Interface
- DATA_W, 64: packet width.
- VC_BIT, 63: packet bit holding the virtual-channel tag.
- HOP_LSB, 48: LSB of the hop-count field.
- HOP_W, 8: hop-count field width.
- STARVE_MAX, 4: consecutive lost contested cycles after which the PE wins.

Ports (one clock `clk`; reset is asynchronous and active-low, port named `reset`):
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- polarity  out  1  current link polarity / VC being transmitted.
- ring_si  in  1  ring pass-through packet valid.
- ring_ri  out  1  ring packet accepted this cycle.
- ring_di  in  DATA_W  ring packet.
- pe_si  in  1  PE injection packet valid.
- pe_ri  out  1  PE packet accepted this cycle.
- pe_di  in  DATA_W  PE packet.
- out_so  out  1  outbound packet valid.
- out_ro  in  1  downstream buffer for VC==polarity is free.
- out_do  out  DATA_W  outbound packet.
- err_hop  out  1  sticky flag: a ring packet arrived with hop count 0.

## Operation
- Polarity register p:
  - reset to 0.
  - toggles on every clock edge.
- Two buffers, buf[0] and buf[1], each DATA_W wide with a valid bit.
- Send side:
  - out_so = valid[p]; out_do = buf[p].
  - On an edge with out_so && out_ro: valid[p] clears. The data register is unchanged.
  - If out_ro is low, the buffer holds until the next cycle with the same polarity.
- Fill side: only buf[~p] may be written. It is eligible when valid[~p]==0.
- Arbitration in an eligible cycle:
  - Only ring_si: ring_ri=1.
  - Only pe_si: pe_ri=1.
  - Both: ring wins, unless starve_cnt==STARVE_MAX, in which case the PE wins.
  - At most one ri is high per cycle.
  - ri is combinational from si, p and valid. It never depends on out_ro.
- starve_cnt:
  - range 0..STARVE_MAX.
  - increments on a contested cycle the PE loses.
  - clears on any PE grant.
  - holds otherwise, including non-eligible cycles.
- Written packet, for both sources: bit VC_BIT is overwritten with ~p.
- Ring packets only: the hop field [HOP_LSB+HOP_W-1:HOP_LSB] is decremented by 1.
  - If the field is 0, it stays 0 (saturates) and err_hop sets.
  - PE packets keep their hop field.
- err_hop clears only on reset.

## Timing
- Reset values (asynchronous, while reset==0):
  - polarity=0; valid[0]=valid[1]=0; buffers=0.
  - out_so=0, out_do=0, starve_cnt=0, err_hop=0.
  - ring_ri and pe_ri are 0 because p toggling is frozen and the arbiter is gated by reset.
- Latency:
  - A packet accepted at edge k (p before the edge = P) lands in buf[~P].
  - After edge k, polarity = ~P, so out_so is high in cycle k+1 and the earliest departure is edge k+1.
  - Every out_ro=0 at a matching-polarity cycle adds 2 cycles.
- Throughput: at most one packet per cycle total, alternating VCs.
- Simultaneous send and fill in the same cycle touch different buffers, so there is no conflict.
- Reset mid-operation drops both buffered packets with no partial state. The first post-reset cycle has polarity 0.
- Backpressure: while valid[~p]==1, both ri stay 0 and starve_cnt holds.

## Test plan
- Reset:
  - Assert reset=0 mid-traffic → all outputs read 0 immediately (asynchronously).
  - Release → polarity reads 0,1,0,1… on successive cycles.
- Single PE inject:
  - pe_di=64'h0000_0003_0000_00AA accepted in a p=0 cycle.
  - Next cycle: out_so=1 and out_do=64'h8000_0003_0000_00AA (VC=1, hop unchanged).
- Ring hop decrement:
  - ring_di with hop=8'h05 accepted → outbound hop=8'h04, VC = ~p.
  - ring_di with hop=0 → outbound hop=0 and err_hop=1, staying 1 until reset.
- Starvation:
  - ring_si=pe_si=1 continuously, out_ro=1 → grants go ring ×4, then PE ×1, repeating.
  - starve_cnt goes 0→4→0.
- Backpressure:
  - out_ro=0 for 3 cycles while buf[1] is valid.
  - buf[1] holds its data.
  - No ri during p=0 cycles.
  - The packet departs at the first p=1 cycle with out_ro=1.
- Back-to-back: alternating ring packets every cycle with out_ro=1 → one departure per cycle, order preserved, no drops.

Source files
------------

// File: rtl/gold_outport_arbiter.sv
// Output-port arbiter for one gold ring direction.
// Shares the outbound link between ring pass-through and PE injection.
// Two VC buffers alternate with the polarity bit:
//   - the buffer matching polarity drives the link;
//   - the other buffer may accept one new packet.
// Ring traffic has priority. A saturating counter gives the PE the
// next contested slot after STARVE_MAX consecutive losses.
module gold_outport_arbiter #(
    parameter int DATA_W     = 64,
    parameter int VC_BIT     = 63,
    parameter int HOP_LSB    = 48,
    parameter int HOP_W      = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    output logic              polarity,
    input  logic              ring_si,
    output logic              ring_ri,
    input  logic [DATA_W-1:0] ring_di,
    input  logic              pe_si,
    output logic              pe_ri,
    input  logic [DATA_W-1:0] pe_di,
    output logic              out_so,
    input  logic              out_ro,
    output logic [DATA_W-1:0] out_do,
    output logic              err_hop
);
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic              r_pol;
    logic [1:0]        r_valid;
    logic [DATA_W-1:0] r_buf [2];
    logic [CNT_W-1:0]  r_starve;
    logic              r_err;

    logic              w_fill_idx;
    logic              w_elig;
    logic              w_pe_turn;
    logic              w_ring_gnt;
    logic              w_pe_gnt;
    logic              w_contested;
    logic              w_send;
    logic [HOP_W-1:0]  w_hop_in;
    logic              w_hop_zero;
    logic [DATA_W-1:0] w_pkt;

    // Only the buffer opposite the current polarity can be filled.
    // The arbiter is held off while reset is asserted.
    assign w_fill_idx  = ~r_pol;
    assign w_elig      = reset & ~r_valid[w_fill_idx];
    assign w_pe_turn   = (r_starve == CNT_W'(STARVE_MAX));
    assign w_contested = w_elig & ring_si & pe_si;
    assign w_pe_gnt    = w_elig & pe_si & (~ring_si | w_pe_turn);
    assign w_ring_gnt  = w_elig & ring_si & ~w_pe_gnt;
    assign w_send      = r_valid[r_pol] & out_ro;
    assign w_hop_in    = ring_di[HOP_LSB +: HOP_W];
    assign w_hop_zero  = (w_hop_in == '0);

    assign polarity = r_pol;
    assign ring_ri  = w_ring_gnt;
    assign pe_ri    = w_pe_gnt;
    assign out_so   = r_valid[r_pol];
    assign out_do   = r_buf[r_pol];
    assign err_hop  = r_err;

    // Build the packet to store.
    // The VC tag is set to the buffer's VC.
    // Ring packets also get a saturating hop-count decrement.
    always_comb begin
        w_pkt = w_pe_gnt ? pe_di : ring_di;
        if (!w_pe_gnt && !w_hop_zero) begin
            w_pkt[HOP_LSB +: HOP_W] = w_hop_in - HOP_W'(1);
        end
        w_pkt[VC_BIT] = w_fill_idx;
    end

    // Update all sequential state on each clock edge.
    // Send and fill always use different buffers, so they never collide.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pol    <= 1'b0;
            r_valid  <= 2'b00;
            r_buf[0] <= '0;
            r_buf[1] <= '0;
            r_starve <= '0;
            r_err    <= 1'b0;
        end else begin
            r_pol <= ~r_pol;
            if (w_send) begin
                r_valid[r_pol] <= 1'b0;
            end
            if (w_ring_gnt || w_pe_gnt) begin
                r_valid[w_fill_idx] <= 1'b1;
                r_buf[w_fill_idx]   <= w_pkt;
            end
            if (w_pe_gnt) begin
                r_starve <= '0;
            end else if (w_contested && (r_starve < CNT_W'(STARVE_MAX))) begin
                r_starve <= r_starve + CNT_W'(1);
            end
            if (w_ring_gnt && w_hop_zero) begin
                r_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_gold_outport_arbiter.sv
// Directed bench for gold_outport_arbiter.
// Per-VC queues hold the packets expected on the link.
// The expected grant, polarity and error state come from the bench's own view of the rules.
module tb_gold_outport_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        polarity;
    logic        ring_si;
    logic        ring_ri;
    logic [63:0] ring_di;
    logic        pe_si;
    logic        pe_ri;
    logic [63:0] pe_di;
    logic        out_so;
    logic        out_ro;
    logic [63:0] out_do;
    logic        err_hop;

    int checks   = 0;
    int failures = 0;

    logic [63:0] q0[$];
    logic [63:0] q1[$];
    int          grant_log[$];
    logic        exp_p;
    int          exp_starve;
    logic        exp_err;

    gold_outport_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .polarity (polarity),
        .ring_si  (ring_si),
        .ring_ri  (ring_ri),
        .ring_di  (ring_di),
        .pe_si    (pe_si),
        .pe_ri    (pe_ri),
        .pe_di    (pe_di),
        .out_so   (out_so),
        .out_ro   (out_ro),
        .out_do   (out_do),
        .err_hop  (err_hop)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle.
    // Inputs are driven and outputs checked just after the falling edge.
    // The expected state then advances across the rising edge.
    task automatic do_cycle(input logic rs, input logic [63:0] rd, input logic ps,
                            input logic [63:0] pd, input logic ro);
        logic        elig;
        logic        eg_r;
        logic        eg_p;
        logic        exp_so;
        logic [63:0] pkt;
        logic [7:0]  hop;
        ring_si = rs;
        ring_di = rd;
        pe_si   = ps;
        pe_di   = pd;
        out_ro  = ro;
        #1;
        chk("polarity", 64'(polarity), 64'(exp_p));
        exp_so = exp_p ? (q1.size() != 0) : (q0.size() != 0);
        chk("out_so", 64'(out_so), 64'(exp_so));
        if (exp_so) chk("out_do", out_do, exp_p ? q1[0] : q0[0]);
        elig = exp_p ? (q0.size() == 0) : (q1.size() == 0);
        eg_p = elig && ps && (!rs || exp_starve == 4);
        eg_r = elig && rs && !eg_p;
        chk("ring_ri", 64'(ring_ri), 64'(eg_r));
        chk("pe_ri", 64'(pe_ri), 64'(eg_p));
        chk("err_hop", 64'(err_hop), 64'(exp_err));
        pkt = eg_p ? pd : rd;
        if (eg_r) begin
            hop = rd[55:48];
            if (hop == 8'h00) exp_err = 1'b1;
            else pkt[55:48] = hop - 8'h01;
        end
        pkt[63] = ~exp_p;
        @(posedge clk);
        if (exp_so && ro) begin
            if (exp_p) void'(q1.pop_front());
            else void'(q0.pop_front());
        end
        if (eg_r || eg_p) begin
            if (exp_p) q0.push_back(pkt);
            else q1.push_back(pkt);
            grant_log.push_back(eg_p ? 2 : 1);
        end
        if (eg_p) exp_starve = 0;
        else if (elig && rs && ps && exp_starve < 4) exp_starve++;
        exp_p = ~exp_p;
        @(negedge clk);
    endtask

    initial begin
        reset   = 1'b0;
        ring_si = 1'b0;
        ring_di = '0;
        pe_si   = 1'b0;
        pe_di   = '0;
        out_ro  = 1'b0;
        exp_p   = 1'b0;
        exp_starve = 0;
        exp_err = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_polarity", 64'(polarity), 64'd0);
        chk("rst_out_so", 64'(out_so), 64'd0);
        chk("rst_out_do", out_do, 64'd0);
        chk("rst_err_hop", 64'(err_hop), 64'd0);
        reset = 1'b1;

        // Single PE inject in a p=0 cycle, then drain.
        do_cycle(1'b0, 64'd0, 1'b1, 64'h0000_0003_0000_00AA, 1'b1);
        chk("pe_inject_so", 64'(out_so), 64'd1);
        chk("pe_inject_do", out_do, 64'h8000_0003_0000_00AA);
        repeat (2) do_cycle(1'b0, 64'd0, 1'b0, 64'd0, 1'b1);

        // Ring hop decrement, then hop=0 saturation with a sticky error.
        do_cycle(1'b1, 64'h0005_0000_0000_1234, 1'b0, 64'd0, 1'b1);
        begin
            logic [63:0] cur;
            cur = out_do;
            chk("hop5_field", 64'(cur[55:48]), 64'h04);
            chk("hop5_vc", 64'(cur[63]), 64'(polarity));
        end
        do_cycle(1'b0, 64'd0, 1'b0, 64'd0, 1'b1);
        do_cycle(1'b1, 64'h0000_0000_0000_5678, 1'b0, 64'd0, 1'b1);
        begin
            logic [63:0] cur;
            cur = out_do;
            chk("hop0_field", 64'(cur[55:48]), 64'h00);
        end
        chk("hop0_err", 64'(err_hop), 64'd1);
        repeat (2) do_cycle(1'b0, 64'd0, 1'b0, 64'd0, 1'b1);

        // Starvation: both sources stay valid.
        // The expected grant pattern is ring x4, then PE, repeating.
        grant_log.delete();
        for (int i = 0; i < 15; i++)
            do_cycle(1'b1, {8'h00, 8'h10, 48'(i)}, 1'b1, {16'h0000, 48'(i + 100)}, 1'b1);
        chk("starve_grants", 64'(grant_log.size()), 64'd15);
        for (int i = 0; i < 15 && i < grant_log.size(); i++)
            chk("starve_pattern", 64'(grant_log[i]), (i % 5 == 4) ? 64'd2 : 64'd1);
        repeat (3) do_cycle(1'b0, 64'd0, 1'b0, 64'd0, 1'b1);

        // Backpressure: out_ro is low for 3 cycles while both sources request.
        if (exp_p) do_cycle(1'b0, 64'd0, 1'b0, 64'd0, 1'b1);
        do_cycle(1'b0, 64'd0, 1'b1, 64'h0000_0007_0000_0BB0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            do_cycle(1'b1, 64'h0003_0000_0000_0C00 + 64'(i), 1'b1,
                     64'h0000_0000_0000_0D00 + 64'(i), 1'b0);
            chk("bp_buf1_hold_q", 64'(q1.size()), 64'd1);
        end
        repeat (4) do_cycle(1'b0, 64'd0, 1'b0, 64'd0, 1'b1);
        chk("bp_drained0", 64'(q0.size()), 64'd0);
        chk("bp_drained1", 64'(q1.size()), 64'd0);

        // Back-to-back ring packets: one departure per cycle.
        for (int i = 0; i < 16; i++)
            do_cycle(1'b1, {8'h00, 8'($urandom_range(1, 255)), 16'(i), 32'($urandom)},
                     1'b0, 64'd0, 1'b1);

        // Asynchronous reset in the middle of traffic.
        ring_si = 1'b1;
        ring_di = 64'h0009_0000_0000_0E00;
        out_ro  = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        chk("arst_polarity", 64'(polarity), 64'd0);
        chk("arst_out_so", 64'(out_so), 64'd0);
        chk("arst_out_do", out_do, 64'd0);
        chk("arst_ring_ri", 64'(ring_ri), 64'd0);
        chk("arst_pe_ri", 64'(pe_ri), 64'd0);
        chk("arst_err_hop", 64'(err_hop), 64'd0);
        q0.delete();
        q1.delete();
        exp_p = 1'b0;
        exp_starve = 0;
        exp_err = 1'b0;
        ring_si = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) do_cycle(1'b0, 64'd0, 1'b0, 64'd0, 1'b1);
        do_cycle(1'b0, 64'd0, 1'b1, 64'h0000_0001_0000_0011, 1'b1);
        do_cycle(1'b0, 64'd0, 1'b0, 64'd0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
